vga_framebuffer: RTL and testbench



---
 rtl/vga_framebuffer.sv | 136 +++++++++++++
 tb/tb_vga_framebuffer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/vga_framebuffer.sv
// 640x480@60 VGA scan-out from a 256x256x24 framebuffer, clocked by a single 50 MHz clock.
// Pixel rate is CLOCK_50/2 via a toggling pixel enable; outputs trail the RAM address by one pixel tick.
module vga_framebuffer #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter int FB_W      = 256,
   parameter int FB_H      = 256
) (
   input  logic        CLOCK_50,
   input  logic        rst,
   input  logic [15:0] fb_wadr,
   input  logic        fb_we,
   input  logic [23:0] fb_d,
   output logic [7:0]  VGA_B,
   output logic        VGA_BLANK_N,
   output logic        VGA_CLK,
   output logic [7:0]  VGA_G,
   output logic        VGA_HS,
   output logic [7:0]  VGA_R,
   output logic        VGA_SYNC_N,
   output logic        VGA_VS
);

   localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int HS_START = H_VISIBLE + H_FRONT;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_VISIBLE + V_FRONT;
   localparam int VS_END   = VS_START + V_SYNC;
   // Counters are at least 8 bits wide so the low byte always forms the RAM address.
   localparam int HW = ($clog2(H_TOTAL) > 8) ? $clog2(H_TOTAL) : 8;
   localparam int VW = ($clog2(V_TOTAL) > 8) ? $clog2(V_TOTAL) : 8;
   localparam int FB_DEPTH = 1 << 16;

   typedef struct packed {
      logic active;
      logic in_win;
      logic hs_n;
      logic vs_n;
   } flags_t;

   localparam flags_t FLAGS_RESET = '{active: 1'b0, in_win: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

   logic          pe_q;
   logic [HW-1:0] hcnt_q, hcnt_d;
   logic [VW-1:0] vcnt_q, vcnt_d;
   flags_t        flags_d, flags_q;
   logic [15:0]   rd_adr_d, rd_adr_q;
   logic [23:0]   rd_data_q;
   logic [23:0]   rgb_d, rgb_q;
   logic          blank_n_q, hs_n_q, vs_n_q;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      hcnt_d = hcnt_q + HW'(1);
      vcnt_d = vcnt_q;
      if (int'(hcnt_q) == H_TOTAL - 1) begin
         hcnt_d = '0;
         if (int'(vcnt_q) == V_TOTAL - 1) begin
            vcnt_d = '0;
         end else begin
            vcnt_d = vcnt_q + VW'(1);
         end
      end
   end

   always_comb begin
      flags_d        = FLAGS_RESET;
      flags_d.active = (int'(hcnt_q) < H_VISIBLE) && (int'(vcnt_q) < V_VISIBLE);
      flags_d.in_win = (int'(hcnt_q) < FB_W) && (int'(vcnt_q) < FB_H);
      flags_d.hs_n   = !((int'(hcnt_q) >= HS_START) && (int'(hcnt_q) < HS_END));
      flags_d.vs_n   = !((int'(vcnt_q) >= VS_START) && (int'(vcnt_q) < VS_END));
      rd_adr_d       = {vcnt_q[7:0], hcnt_q[7:0]};
   end

   // Colour is forced to zero both while blanked and for active pixels outside the window.
   always_comb begin
      rgb_d = '0;
      if (flags_q.active && flags_q.in_win) begin
         rgb_d = rd_data_q;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         pe_q      <= 1'b0;
         hcnt_q    <= '0;
         vcnt_q    <= '0;
         flags_q   <= FLAGS_RESET;
         rd_adr_q  <= '0;
         rgb_q     <= '0;
         blank_n_q <= 1'b0;
         hs_n_q    <= 1'b1;
         vs_n_q    <= 1'b1;
      end else begin
         pe_q <= ~pe_q;
         if (pe_q) begin
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            flags_q   <= flags_d;
            rd_adr_q  <= rd_adr_d;
            rgb_q     <= rgb_d;
            blank_n_q <= flags_q.active;
            hs_n_q    <= flags_q.hs_n;
            vs_n_q    <= flags_q.vs_n;
         end
      end
   end

   // NOTE: the framebuffer is deliberately left out of reset; clearing 64K words is not a one-cycle job.
   logic [23:0] mem [FB_DEPTH];

   always_ff @(posedge CLOCK_50) begin
      if (fb_we) begin
         mem[fb_wadr] <= fb_d;
      end
      rd_data_q <= mem[rd_adr_q];
   end

   assign VGA_CLK     = pe_q;
   assign VGA_R       = rgb_q[23:16];
   assign VGA_G       = rgb_q[15:8];
   assign VGA_B       = rgb_q[7:0];
   assign VGA_BLANK_N = blank_n_q;
   assign VGA_HS      = hs_n_q;
   assign VGA_VS      = vs_n_q;
   assign VGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_vga_framebuffer.sv
// Directed bench for vga_framebuffer: reset values, H/V timing, pixel data, window edge and mid-frame reset.
// The vertical geometry is shortened so whole frames fit in a short run; horizontal timing is full size.
module tb_vga_framebuffer;

   localparam int V_VIS  = 8;
   localparam int V_FP   = 2;
   localparam int V_SW   = 2;
   localparam int V_BP   = 2;
   localparam int LINE   = 1600;
   localparam int FRAME  = (V_VIS + V_FP + V_SW + V_BP) * LINE;
   // Pixel p of the scan appears on the outputs at edge 2*p+4 after reset release.
   localparam int LAT    = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] fb_wadr;
   logic        fb_we;
   logic [23:0] fb_d;
   logic [7:0]  vga_r, vga_g, vga_b;
   logic        vga_blank_n, vga_clk, vga_hs, vga_vs, vga_sync_n;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   vga_framebuffer #(
      .V_VISIBLE (V_VIS),
      .V_FRONT   (V_FP),
      .V_SYNC    (V_SW),
      .V_BACK    (V_BP)
   ) dut (
      .CLOCK_50    (clk),
      .rst         (rst),
      .fb_wadr     (fb_wadr),
      .fb_we       (fb_we),
      .fb_d        (fb_d),
      .VGA_B       (vga_b),
      .VGA_BLANK_N (vga_blank_n),
      .VGA_CLK     (vga_clk),
      .VGA_G       (vga_g),
      .VGA_HS      (vga_hs),
      .VGA_R       (vga_r),
      .VGA_SYNC_N  (vga_sync_n),
      .VGA_VS      (vga_vs)
   );

   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic step_to(input int target);
      if (target > cyc) step(target - cyc);
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         0:       return vga_hs;
         1:       return vga_vs;
         default: return vga_blank_n;
      endcase
   endfunction

   task automatic wait_for(input string tag, input int sel, input logic lvl, input int budget,
                           output int at);
      int n = 0;
      while (sig(sel) !== lvl && n < budget) begin
         step(1);
         n++;
      end
      check({tag, "_reached"}, {31'b0, sig(sel)}, {31'b0, lvl});
      at = cyc;
   endtask

   task automatic check_pixel(input string tag, input logic [23:0] rgb, input logic blank_n);
      check({tag, "_r"}, {24'b0, vga_r}, {24'b0, rgb[23:16]});
      check({tag, "_g"}, {24'b0, vga_g}, {24'b0, rgb[15:8]});
      check({tag, "_b"}, {24'b0, vga_b}, {24'b0, rgb[7:0]});
      check({tag, "_blank_n"}, {31'b0, vga_blank_n}, {31'b0, blank_n});
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_clk"}, {31'b0, vga_clk}, 32'd0);
      check({tag, "_hs"}, {31'b0, vga_hs}, 32'd1);
      check({tag, "_vs"}, {31'b0, vga_vs}, 32'd1);
      check({tag, "_sync_n"}, {31'b0, vga_sync_n}, 32'd0);
      check_pixel(tag, 24'h000000, 1'b0);
   endtask

   task automatic write_fb(input logic [15:0] adr, input logic [23:0] d);
      fb_wadr = adr;
      fb_d    = d;
      fb_we   = 1'b1;
      step(1);
      fb_we   = 1'b0;
   endtask

   initial begin
      int t_line, t_hs, t_at, t_vs, t_rel, t_blank;
      rst     = 1'b1;
      fb_we   = 1'b0;
      fb_wadr = '0;
      fb_d    = '0;

      step(4);
      check_reset("rst_hold");

      // Preload while still in reset so scan-out starts with known content.
      write_fb(16'h0000, 24'hFF0000);
      write_fb(16'h0105, 24'h00FF00);
      write_fb(16'h00FF, 24'h123456);
      check_reset("rst_after_writes");

      rst = 1'b0;
      cyc = 0;
      step(1);
      check("clk_e1", {31'b0, vga_clk}, 32'd1);
      check("blank_e1", {31'b0, vga_blank_n}, 32'd0);
      step(1);
      check("clk_e2", {31'b0, vga_clk}, 32'd0);
      step(1);
      check("clk_e3", {31'b0, vga_clk}, 32'd1);
      step(1);
      check("clk_e4", {31'b0, vga_clk}, 32'd0);
      check("hs_line0", {31'b0, vga_hs}, 32'd1);
      check_pixel("px_0_0", 24'hFF0000, 1'b1);
      t_line = cyc;

      step_to(LAT + 2 * 255);
      check_pixel("px_255_0", 24'h123456, 1'b1);
      step_to(LAT + 2 * 256);
      check_pixel("px_256_0", 24'h000000, 1'b1);

      wait_for("blank_fall", 2, 1'b0, 2000, t_at);
      check("blank_high_cycles", t_at - t_line, 32'd1280);
      wait_for("hs_fall0", 0, 1'b0, 2000, t_hs);
      check("hs_fall_offset", t_hs - t_line, 32'd1312);
      wait_for("hs_rise0", 0, 1'b1, 2000, t_at);
      check("hs_low_cycles", t_at - t_hs, 32'd192);

      // A write mid-frame must show up when that pixel is next scanned.
      write_fb(16'h010A, 24'h00ABCD);
      step_to(LAT + 2 * (800 + 5));
      check_pixel("px_5_1", 24'h00FF00, 1'b1);
      step_to(LAT + 2 * (800 + 10));
      check_pixel("px_10_1", 24'h00ABCD, 1'b1);
      check("vs_line1", {31'b0, vga_vs}, 32'd1);

      wait_for("hs_fall1", 0, 1'b0, 2000, t_at);
      check("hs_period", t_at - t_hs, LINE);

      wait_for("vs_fall0", 1, 1'b0, 40000, t_vs);
      check("vs_fall_offset", t_vs - t_line, (V_VIS + V_FP) * LINE);
      wait_for("vs_rise0", 1, 1'b1, 5000, t_at);
      check("vs_low_cycles", t_at - t_vs, 32'd3200);
      wait_for("vs_fall1", 1, 1'b0, 30000, t_at);
      check("vs_period", t_at - t_vs, FRAME);

      // Frame 2, line 5, pixel 300: active but outside the framebuffer window.
      step_to(LAT + 2 * (2 * (FRAME / 2) + 5 * 800 + 300));
      check_pixel("px_300_5", 24'h000000, 1'b1);

      rst = 1'b1;
      step(1);
      check_reset("rst_mid");
      rst   = 1'b0;
      t_rel = cyc;
      wait_for("blank_rise_mid", 2, 1'b1, 100, t_blank);
      check("restart_latency", t_blank - t_rel, LAT);
      check_pixel("px_0_0_restart", 24'hFF0000, 1'b1);
      wait_for("hs_fall_mid", 0, 1'b0, 2000, t_at);
      check("hs_fall_after_restart", t_at - t_blank, 32'd1312);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
